ex_mem: RTL
===========

Name: ex_mem

Overview:
- Pipeline register between the execute stage and the memory-access stage of the 5-stage integer core.
- Captures the ex results each cycle: GPR write, HI/LO write, and the two-cycle multiply-accumulate scratch state (hilo_temp/cnt).
- Honours stall and flush from the control unit, inserts bubbles into mem, and counts inserted bubbles for performance monitoring.

Parameters:
- REG_W, 32, GPR / HI / LO data width.
- ADDR_W, 5, GPR address width.
- CNT_W, 2, width of the multi-cycle step counter.
- PERF_W, 32, bubble counter width (saturating).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset; 0 = reset.
- stall_ex  in  1  ex stage stalled this cycle.
- stall_mem  in  1  mem stage stalled this cycle.
- flush  in  1  exception/redirect flush; kills the in-flight entry.
- ex_wd  in  ADDR_W  GPR destination from ex.
- ex_wreg  in  1  GPR write enable from ex.
- ex_wdata  in  REG_W  GPR write data from ex.
- ex_whilo  in  1  HI/LO write enable from ex.
- ex_hi  in  REG_W  HI value from ex.
- ex_lo  in  REG_W  LO value from ex.
- hilo_temp_i  in  2*REG_W  madd/msub partial product from ex.
- cnt_i  in  CNT_W  madd/msub step from ex.
- mem_wd  out  ADDR_W  to mem stage.
- mem_wreg  out  1  to mem stage.
- mem_wdata  out  REG_W  to mem stage.
- mem_whilo  out  1  to mem stage.
- mem_hi  out  REG_W  to mem stage.
- mem_lo  out  REG_W  to mem stage.
- hilo_temp_o  out  2*REG_W  fed back to ex.
- cnt_o  out  CNT_W  fed back to ex.
- bubble_cnt  out  PERF_W  number of bubbles inserted since reset.

Behaviour:
- All outputs are registered and update on the rising clk edge only.
- Latency is 1 cycle from the ex_* inputs to the mem_* outputs.
- Reset (rst=0, asynchronous): every output is 0, mem_wd = NOPRegAddr (0), and both write enables are WriteDisable.
- Per-edge priority (first match wins):
  1. flush=1: mem_* cleared to the reset values; hilo_temp_o=0; cnt_o=0. bubble_cnt is unchanged. flush overrides both stalls.
  2. stall_ex=1, stall_mem=0 (bubble): mem_* cleared to the reset values; hilo_temp_o<=hilo_temp_i; cnt_o<=cnt_i; bubble_cnt increments by 1.
  3. stall_ex=1, stall_mem=1 (hold): every output keeps its value.
  4. stall_ex=0, stall_mem=0 (advance): mem_*<=ex_*; hilo_temp_o=0; cnt_o=0.
  5. stall_ex=0, stall_mem=1: illegal combination. The register holds exactly as in case 3, and a simulation-only assertion fires.
- Multi-cycle madd/msub:
  - In step 1, ex stalls itself. ex_mem latches the partial product and cnt_i=1 so ex reads them back next cycle.
  - In step 2, ex releases the stall. ex_mem advances and clears the scratch state.
  - Scratch state must survive any number of consecutive hold cycles.
- bubble_cnt saturates at all-ones. It is not cleared by flush, only by reset.
- Reset asserted mid-madd: scratch state and all outputs go to 0 immediately; no partial result ever reaches mem.
- No combinational path from any input to any output.

Decomposition:
- Shared defines:
  - RstEnable is redefined as 1'b0 for this block family.
  - Also shared: ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, RegBus, RegAddrBus, DoubleRegBus.
  - A stall-vector index constant for ex and for mem, so the control unit can drive stall_ex/stall_mem from its stall bus.
- One natural sub-module: ex_mem_perf_cnt, the saturating PERF_W counter with inc/rst. Everything else stays flat.

Test Plan:
- Reset then advance:
  - Stimulus: rst=0 for 2 cycles, then rst=1; ex_wd=5, ex_wreg=1, ex_wdata=32'hDEADBEEF; no stall.
  - Required: mem_wd=5, mem_wdata=32'hDEADBEEF one cycle later; all outputs 0 during reset.
- Madd two-step:
  - Stimulus: cycle N stall_ex=1, stall_mem=0, hilo_temp_i=64'h0000_0001_0000_0002, cnt_i=1; cycle N+1 stall_ex=0.
  - Required: after N, hilo_temp_o=64'h0000_0001_0000_0002, cnt_o=1, mem_wreg=0, bubble_cnt=1; after N+1, cnt_o=0, hilo_temp_o=0, mem_* carry ex values.
- Hold:
  - Stimulus: load mem_wdata=32'h12345678, then stall_ex=stall_mem=1 for 3 cycles while ex_wdata changes.
  - Required: mem_wdata stays 32'h12345678; bubble_cnt unchanged.
- Flush over stall:
  - Stimulus: flush=1 with stall_ex=stall_mem=1 and cnt_o=1.
  - Required: next edge all mem_* = 0, cnt_o=0, bubble_cnt unchanged.
- Async reset mid-madd:
  - Stimulus: drop rst between clock edges while cnt_o=1.
  - Required: outputs go to 0 before the next edge.
- Saturation:
  - Stimulus: preload/force bubble_cnt=32'hFFFF_FFFE, then apply 3 bubbles.
  - Required: bubble_cnt=32'hFFFF_FFFF and it stays there.

Source files
------------

// File: rtl/ex_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_pkg                                                |
// | Purpose  : Shared constants and types for the ex/mem pipeline        |
// |            register family: reset/write-enable encodings, bus types, |
// |            stall-bus indices and the per-edge action decoder.        |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ex_mem_pkg;

  // Reset is active-low for this block family.
  localparam logic RstEnable    = 1'b0;
  localparam logic RstDisable   = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef logic [31:0] RegBus;
  typedef logic [4:0]  RegAddrBus;
  typedef logic [63:0] DoubleRegBus;

  localparam RegBus     ZeroWord   = 32'h0000_0000;
  localparam RegAddrBus NOPRegAddr = 5'd0;

  // Positions of the ex and mem bits on the control unit's stall bus
  // (pc, if, id, ex, mem, wb).
  localparam int STALL_W       = 6;
  localparam int STALL_IDX_EX  = 3;
  localparam int STALL_IDX_MEM = 4;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } pipe_act_e;

  // Priority: flush, then bubble, then hold. The illegal combination
  // (ex running while mem stalls) collapses onto hold.
  function automatic pipe_act_e pipe_action(input logic flush,
                                            input logic stall_ex,
                                            input logic stall_mem);
    pipe_act_e act;
    if (flush)                      act = ACT_FLUSH;
    else if (stall_ex && !stall_mem) act = ACT_BUBBLE;
    else if (stall_ex || stall_mem) act = ACT_HOLD;
    else                            act = ACT_ADVANCE;
    return act;
  endfunction

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/ex_mem_perf_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_perf_cnt                                           |
// | Purpose  : Saturating event counter used to count inserted bubbles.  |
// | Ports    : clk     - rising-edge clock                               |
// |            rst     - asynchronous active-low reset                   |
// |            inc_i   - count one event this edge                       |
// |            count_o - current count, sticks at all-ones               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ex_mem_perf_cnt
  import ex_mem_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  output logic [PERF_W-1:0] count_o
);

  logic [PERF_W-1:0] count_q;
  logic [PERF_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {PERF_W{1'b1}})) begin
      count_d = count_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : ex_mem_perf_cnt
`default_nettype wire

// File: rtl/ex_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem                                                    |
// | Purpose  : Execute -> memory pipeline register. Carries GPR and      |
// |            HI/LO writes to mem, holds the madd/msub scratch state    |
// |            fed back to ex, and counts bubbles inserted into mem.     |
// | Ports    : clk, rst (async, active-low)                              |
// |            stall_ex, stall_mem, flush         - pipeline control     |
// |            ex_wd/wreg/wdata/whilo/hi/lo       - results from ex      |
// |            hilo_temp_i, cnt_i                 - scratch from ex      |
// |            mem_wd/wreg/wdata/whilo/hi/lo      - registered to mem    |
// |            hilo_temp_o, cnt_o                 - registered back to ex|
// |            bubble_cnt                         - saturating perf count|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int REG_W  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_ex,
  input  logic               stall_mem,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  ex_wd,
  input  logic               ex_wreg,
  input  logic [REG_W-1:0]   ex_wdata,
  input  logic               ex_whilo,
  input  logic [REG_W-1:0]   ex_hi,
  input  logic [REG_W-1:0]   ex_lo,
  input  logic [2*REG_W-1:0] hilo_temp_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic [ADDR_W-1:0]  mem_wd,
  output logic               mem_wreg,
  output logic [REG_W-1:0]   mem_wdata,
  output logic               mem_whilo,
  output logic [REG_W-1:0]   mem_hi,
  output logic [REG_W-1:0]   mem_lo,
  output logic [2*REG_W-1:0] hilo_temp_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [PERF_W-1:0]  bubble_cnt
);

  pipe_act_e act;

  logic [ADDR_W-1:0]  wd_q,    wd_d;
  logic               wreg_q,  wreg_d;
  logic [REG_W-1:0]   wdata_q, wdata_d;
  logic               whilo_q, whilo_d;
  logic [REG_W-1:0]   hi_q,    hi_d;
  logic [REG_W-1:0]   lo_q,    lo_d;
  logic [2*REG_W-1:0] temp_q,  temp_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  always_comb begin
    act     = pipe_action(flush, stall_ex, stall_mem);
    // Hold is the default; the scratch state in particular must survive
    // any run of hold cycles between the two madd/msub steps.
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    temp_d  = temp_q;
    cnt_d   = cnt_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        wd_d    = '0;
        wreg_d  = WriteDisable;
        wdata_d = '0;
        whilo_d = WriteDisable;
        hi_d    = '0;
        lo_d    = '0;
        // A bubble is how ex parks a madd/msub partial product here;
        // a flush discards it.
        if (act == ACT_BUBBLE) begin
          temp_d = hilo_temp_i;
          cnt_d  = cnt_i;
        end else begin
          temp_d = '0;
          cnt_d  = '0;
        end
      end
      ACT_ADVANCE: begin
        wd_d    = ex_wd;
        wreg_d  = ex_wreg;
        wdata_d = ex_wdata;
        whilo_d = ex_whilo;
        hi_d    = ex_hi;
        lo_d    = ex_lo;
        temp_d  = '0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wd_q    <= '0;
      wreg_q  <= WriteDisable;
      wdata_q <= '0;
      whilo_q <= WriteDisable;
      hi_q    <= '0;
      lo_q    <= '0;
      temp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      temp_q  <= temp_d;
      cnt_q   <= cnt_d;
    end
  end

  ex_mem_perf_cnt #(
    .PERF_W (PERF_W)
  ) u_perf_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (act == ACT_BUBBLE),
    .count_o (bubble_cnt)
  );

  assign mem_wd      = wd_q;
  assign mem_wreg    = wreg_q;
  assign mem_wdata   = wdata_q;
  assign mem_whilo   = whilo_q;
  assign mem_hi      = hi_q;
  assign mem_lo      = lo_q;
  assign hilo_temp_o = temp_q;
  assign cnt_o       = cnt_q;

`ifndef SYNTHESIS
  // ex must never run ahead of a stalled mem stage.
  a_no_ex_run_mem_stall : assert property (
    @(posedge clk) disable iff (rst == RstEnable)
      !(!flush && !stall_ex && stall_mem)
  );
`endif

endmodule : ex_mem
`default_nettype wire
